// File: rtl/spi_slave_sync.sv
// SPI mode-0 slave (MSB first) running entirely on the system clock; sclk/ss/MOSI are
// synchronised and edge-detected. Optional macro SPI_SLAVE_UNDERRUN_EN adds an underrun strobe and an all-ones filler word.
module spi_slave_sync #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  sclk,
  input  logic                  ss,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  done,
  output logic                  busy
`ifdef SPI_SLAVE_UNDERRUN_EN
  ,
  output logic                  underrun
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
`ifdef SPI_SLAVE_UNDERRUN_EN
  localparam logic [DATA_WIDTH-1:0] FILL_WORD = {DATA_WIDTH{1'b1}};
`else
  localparam logic [DATA_WIDTH-1:0] FILL_WORD = {DATA_WIDTH{1'b0}};
`endif

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_dly_q, ss_dly_q;
  logic [SYNC_STAGES:0]   flush_q;
  logic                   armed_q, armed_d;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  hold_q, hold_d;
  logic                   hold_empty_q, hold_empty_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   miso_q, miso_d;
  logic                   start_word_s;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic                   underrun_q, underrun_d;
`endif

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise_s, sclk_fall_s, ss_rise_s, ss_fall_s;

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_dly_q;
  assign sclk_fall_s = ~sclk_s & sclk_dly_q;
  assign ss_rise_s   = ss_s & ~ss_dly_q;
  assign ss_fall_s   = ~ss_s & ss_dly_q;

  // Synchronisers preset to idle; armed_q blocks a fake ss fall right after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= {SYNC_STAGES{1'b0}};
      ss_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
      sclk_dly_q  <= 1'b0;
      ss_dly_q    <= 1'b1;
      flush_q     <= {(SYNC_STAGES+1){1'b0}};
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sclk_dly_q  <= sclk_s;
      ss_dly_q    <= ss_s;
      flush_q     <= {flush_q[SYNC_STAGES-1:0], 1'b1};
      armed_q     <= armed_d;
    end
  end

  // Next-state logic for the shift FSM, holding register and strobes.
  always_comb begin
    state_d      = state_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    hold_empty_d = hold_empty_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    start_word_s = 1'b0;
    armed_d      = armed_q | (flush_q[SYNC_STAGES] & ss_s);
`ifdef SPI_SLAVE_UNDERRUN_EN
    underrun_d   = 1'b0;
`endif

    if (tx_valid && hold_empty_q) begin
      hold_d       = tx_data;
      hold_empty_d = 1'b0;
    end else begin
      hold_d       = hold_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (ss_fall_s && armed_q) begin
          state_d      = ST_SHIFT;
          start_word_s = 1'b1;
          cnt_d        = CNT_ZERO;
        end else begin
          cnt_d        = CNT_ZERO;
        end
      end
      ST_SHIFT: begin
        if (ss_rise_s) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (sclk_rise_s) begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
          cnt_d      = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
          end else begin
            rx_valid_d = 1'b0;
          end
        end else if (sclk_fall_s) begin
          if (cnt_q == CNT_FULL) begin
            start_word_s = 1'b1;
            cnt_d        = CNT_ZERO;
          end else begin
            tx_shift_d   = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // A same-cycle load is never bypassed: only an already-full register is consumed.
    if (start_word_s) begin
      if (!hold_empty_q) begin
        tx_shift_d   = hold_q;
        hold_empty_d = 1'b1;
      end else begin
        tx_shift_d   = FILL_WORD;
`ifdef SPI_SLAVE_UNDERRUN_EN
        underrun_d   = 1'b1;
`endif
      end
    end else begin
      start_word_s = 1'b0;
    end

    if (state_d == ST_SHIFT) begin
      miso_d = tx_shift_d[DATA_WIDTH-1];
    end else begin
      miso_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      tx_shift_q   <= {DATA_WIDTH{1'b0}};
      rx_shift_q   <= {DATA_WIDTH{1'b0}};
      cnt_q        <= CNT_ZERO;
      hold_q       <= {DATA_WIDTH{1'b0}};
      hold_empty_q <= 1'b1;
      rx_data_q    <= {DATA_WIDTH{1'b0}};
      rx_valid_q   <= 1'b0;
      miso_q       <= 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
      underrun_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      hold_empty_q <= hold_empty_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      miso_q       <= miso_d;
`ifdef SPI_SLAVE_UNDERRUN_EN
      underrun_q   <= underrun_d;
`endif
    end
  end

  assign MISO     = miso_q;
  assign tx_ready = hold_empty_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign done     = rx_valid_q;
  assign busy     = ~ss_s;
`ifdef SPI_SLAVE_UNDERRUN_EN
  assign underrun = underrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: a bit-banged mode-0 master with a 4-clock sclk half-period.
module tb_spi_slave_sync;

  localparam int HP = 4;
`ifdef SPI_SLAVE_UNDERRUN_EN
  localparam logic [15:0] FILL = 16'h00FF;
`else
  localparam logic [15:0] FILL = 16'h0000;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       sclk = 1'b0;
  logic       ss = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       done;
  logic       busy;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic       underrun;
`endif

  spi_slave_sync #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .sclk    (sclk),
    .ss      (ss),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .done    (done),
    .busy    (busy)
`ifdef SPI_SLAVE_UNDERRUN_EN
    ,
    .underrun(underrun)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int rx_cnt = 0;
  int ur_cnt = 0;
  logic [7:0] rx_last = 8'h00;
  logic [7:0] rx_prev = 8'h00;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (rx_valid === 1'b1) begin
      rx_cnt  <= rx_cnt + 1;
      rx_prev <= rx_last;
      rx_last <= rx_data;
      check("done_with_rx_valid", {15'd0, done}, 16'd1);
    end
`ifdef SPI_SLAVE_UNDERRUN_EN
    if (underrun === 1'b1) ur_cnt <= ur_cnt + 1;
`endif
  end

  task automatic load(input logic [7:0] d);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin
      wait_clk(1);
      n++;
    end
    check("load_ready_seen", {15'd0, tx_ready}, 16'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  // Sends nbits of mo starting at bit index top; ss rises together with the final sclk fall.
  task automatic xfer(input int nbits, input logic [15:0] mo, input int top,
                      input bit chk_ready, output logic [15:0] mi);
    mi = 16'h0000;
    ss = 1'b0;
    if (chk_ready) begin
      wait_clk(2);
      check("tx_ready_before_start", {15'd0, tx_ready}, 16'd0);
      wait_clk(1);
      check("tx_ready_after_start", {15'd0, tx_ready}, 16'd1);
      wait_clk(3);
    end else begin
      wait_clk(6);
    end
    check("busy_in_frame", {15'd0, busy}, 16'd1);
    for (int i = 0; i < nbits; i++) begin
      MOSI = mo[top-i];
      wait_clk(HP);
      mi = {mi[14:0], MISO};
      sclk = 1'b1;
      wait_clk(HP);
      sclk = 1'b0;
      if (i == nbits - 1) ss = 1'b1;
    end
    wait_clk(HP + 2);
    check("busy_after_frame", {15'd0, busy}, 16'd0);
  endtask

  initial begin
    logic [15:0] mi;
    int rx0, ur0;
    logic miso_seen;

    #2 reset_n = 1'b0;
    wait_clk(2);
    check("rst_miso", {15'd0, MISO}, 16'd0);
    check("rst_tx_ready", {15'd0, tx_ready}, 16'd1);
    check("rst_rx_data", {8'd0, rx_data}, 16'h0000);
    check("rst_rx_valid", {15'd0, rx_valid}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
`ifdef SPI_SLAVE_UNDERRUN_EN
    check("rst_underrun", {15'd0, underrun}, 16'd0);
`endif
    reset_n = 1'b1;
    miso_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      wait_clk(1);
      miso_seen = miso_seen | MISO | rx_valid;
    end
    check("idle_miso_quiet", {15'd0, miso_seen}, 16'd0);

    // Master to slave.
    rx0 = rx_cnt;
    xfer(8, 16'h00AA, 7, 1'b0, mi);
    check("aa_pulses", 16'(rx_cnt - rx0), 16'd1);
    check("aa_rx_data", {8'd0, rx_data}, 16'h00AA);
    check("aa_miso_fill", mi, FILL);

    // Slave to master.
    load(8'h6D);
    rx0 = rx_cnt;
    xfer(8, 16'h0000, 7, 1'b1, mi);
    check("6d_master_rx", mi, 16'h006D);
    check("6d_rx_data", {8'd0, rx_data}, 16'h0000);
    check("6d_pulses", 16'(rx_cnt - rx0), 16'd1);

    // Back-to-back with a reload during the first word.
    load(8'h12);
    rx0 = rx_cnt;
    fork
      xfer(16, 16'hC35A, 15, 1'b0, mi);
      begin
        wait_clk(30);
        load(8'h34);
      end
    join
    check("b2b_pulses", 16'(rx_cnt - rx0), 16'd2);
    check("b2b_first", {8'd0, rx_prev}, 16'h00C3);
    check("b2b_second", {8'd0, rx_last}, 16'h005A);
    check("b2b_master_rx", mi, 16'h1234);

    // Abort after five bits, then a full word.
    rx0 = rx_cnt;
    xfer(5, 16'h00F0, 7, 1'b0, mi);
    check("abort_no_pulse", 16'(rx_cnt - rx0), 16'd0);
    check("abort_rx_kept", {8'd0, rx_data}, 16'h005A);
    xfer(8, 16'h000F, 7, 1'b0, mi);
    check("after_abort_pulses", 16'(rx_cnt - rx0), 16'd1);
    check("after_abort_rx", {8'd0, rx_data}, 16'h000F);

    // Underrun: no load before the word.
    ur0 = ur_cnt;
    xfer(8, 16'h0055, 7, 1'b0, mi);
    check("underrun_master_rx", mi, FILL);
`ifdef SPI_SLAVE_UNDERRUN_EN
    check("underrun_pulses", 16'(ur_cnt - ur0), 16'd1);
`else
    check("no_underrun_count", 16'(ur_cnt - ur0), 16'd0);
`endif
    check("underrun_rx_data", {8'd0, rx_data}, 16'h0055);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
- SPI slave (mode 0: CPOL=0, CPHA=0; MSB first) that runs entirely on the system clock; it is the counterpart of the team's SPI master.
- sclk, ss and MOSI are treated as asynchronous inputs: synchronised, then edge-detected.
- Presents a tx_valid/tx_ready load interface and a one-cycle rx_valid/done strobe to local logic, so the slave needs no sclk clock domain.
- Supports back-to-back words while ss stays low.

Parameters:
- DATA_WIDTH, 8, shift length in bits.
- SYNC_STAGES, 2, flip-flop stages on the sclk/ss/MOSI synchronisers (minimum 2).

Ports:
- clock  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- sclk  input  1  SPI clock from the master; asynchronous.
- ss  input  1  slave select, active low; asynchronous.
- MOSI  input  1  master-out data; asynchronous.
- MISO  output  1  slave-out data.
- tx_data  input  DATA_WIDTH  word to return to the master.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  tx holding register is empty.
- rx_data  output  DATA_WIDTH  last word received completely.
- rx_valid  output  1  one-cycle strobe: rx_data updated.
- done  output  1  one-cycle strobe: word finished (same cycle as rx_valid).
- busy  output  1  synced ss is low.

Behaviour:
- Reset values (async, while reset_n=0): MISO=0, tx_ready=1, rx_data=0, rx_valid=0, done=0, busy=0. Synchronisers are preset to the idle state (sclk=0, ss=1). The shift register, bit counter and holding register are cleared.
- Synchronisation: each of sclk, ss and MOSI passes through SYNC_STAGES flops, plus one delay flop used for edge detection.
  - Sampling latency from a pin edge to the internal event is SYNC_STAGES+1 clocks.
  - Required timing: sclk high and low times are each at least SYNC_STAGES+2 clocks. The master's clock_div must satisfy this; below it, behaviour is undefined.
- TX holding register:
  - A load is accepted when tx_valid & tx_ready; tx_ready drops the next cycle.
  - The holding register is consumed at word start; tx_ready returns to 1 the following cycle.
  - A load in the same cycle as word start is not bypassed: the current word uses the old contents (or the filler), and the new data is kept for the next word.
- States: IDLE, SHIFT.
  - IDLE→SHIFT on a synced ss falling edge. In that cycle: shift register ← holding register if full, otherwise the filler word; bit counter ← 0. MISO shows shift[MSB] from the next cycle.
  - SHIFT, synced sclk rising edge: rx_shift ← {rx_shift[DATA_WIDTH-2:0], MOSI_sync}; bit counter +1.
  - SHIFT, synced sclk falling edge:
    - If bit counter < DATA_WIDTH: tx shift left by one, so MISO presents the next bit.
    - If bit counter == DATA_WIDTH: load the next word from the holding register or the filler, and reset the counter to 0 (back-to-back streaming).
  - Word completion, in the cycle after the DATA_WIDTH-th rising-edge sample: rx_data ← rx_shift; rx_valid=1 and done=1 for exactly 1 clock.
  - SHIFT→IDLE on a synced ss rising edge, at any point.
    - Partial word (counter not equal to 0 or DATA_WIDTH): discarded. rx_data is unchanged, no strobe, counter cleared.
    - A completion strobe already generated is not revoked.
- MISO is driven 0 in IDLE. There is no tristate; any bus sharing is done externally.
- busy = synced ss low.
- An sclk edge while ss is high is ignored.
- A simultaneous ss rise and sclk edge: ss wins.
- Asserting reset_n mid-transfer clears everything immediately. The slave then ignores traffic until the next ss falling edge.

Optional Feature:
- Macro: SPI_SLAVE_UNDERRUN_EN.
- Defined:
  - Adds output underrun (1 bit, reset 0).
  - underrun pulses for 1 clock when a word starts with an empty holding register.
  - Filler word is all ones (8'hFF).
- Undefined:
  - No underrun port.
  - Filler word is all zeros.

Test Plan:
- Reset then idle: pulse reset_n low for 2 clocks with ss=1 → all outputs at reset values; tx_ready=1; MISO=0 for 50 clocks.
- Master→slave: master sends 8'hAA with clock_div giving a 4-clock sclk half-period → exactly one rx_valid/done pulse, rx_data=8'hAA, busy high only while ss is low.
- Slave→master: load tx_data=8'h6D before ss falls; master sends 8'h00 → master receives 8'h6D; slave rx_data=8'h00; tx_ready returns to 1 one cycle after word start.
- Back-to-back: ss held low for 16 sclk periods, tx loaded with 8'h12 and then 8'h34 (second load during the first word); master sends 8'hC3, 8'h5A → two rx_valid pulses with rx_data 8'hC3 then 8'h5A; master receives 8'h12, 8'h34.
- Abort: ss rises after 5 sclk periods during 8'hF0 → no rx_valid; rx_data keeps its previous value; the next full transfer of 8'h0F completes correctly.
- Underrun: no tx load before transfer → master receives 8'hFF and underrun pulses once with SPI_SLAVE_UNDERRUN_EN defined; master receives 8'h00 and the port is absent without it.
